// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 iterative core: round count, control
// FSM state encoding and the key-schedule round constant.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SUB,
    MIX,
    DONE
  } aes_ctrl_state_t;

  // Round constant for AES-128, indexed by round number; round 0 has none.
  function automatic logic [7:0] aes_rcon(logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1B;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with a registered
// falling-edge detector on the synchronized level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              level_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain      <= '0;
      level_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge
      // value, so the chain shifts one stage per clock instead of collapsing.
      chain      <= {chain[STAGES-2:0], din};
      level_prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign fall  = level_prev & ~level;

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 datapath: starts on the falling
// edge of the MCU load pin, runs the initial AddRoundKey then NR rounds.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR          = AES_NR,
  parameter int SBOX_LAT    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic       init_we,
  output logic       sbox_en,
  output logic       state_we,
  output logic       key_we,
  output logic       last_round,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       busy,
  output logic       done
);

  localparam int RW = $clog2(NR + 1);
  localparam int WW = $clog2(SBOX_LAT + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NR);
  localparam logic [WW-1:0] LAST_WAIT  = WW'(SBOX_LAT - 1);

  aes_ctrl_state_t state_q, state_d;
  logic [RW-1:0]   round_q, round_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            load_s;
  logic            start;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (load),
    .level (load_s),
    .fall  (start)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here is defaulted first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    round_d  = round_q;
    wait_d   = wait_q;
    init_we  = 1'b0;
    sbox_en  = 1'b0;
    state_we = 1'b0;
    key_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        round_d = '0;
        if (start) state_d = INIT;
      end
      INIT: begin
        init_we = 1'b1;
        busy    = 1'b1;
        wait_d  = '0;
        if (load_s) begin
          state_d = IDLE;
          round_d = '0;
        end else begin
          state_d = SUB;
          round_d = RW'(1);
        end
      end
      SUB: begin
        sbox_en = 1'b1;
        busy    = 1'b1;
        if (load_s) begin
          state_d = IDLE;
          round_d = '0;
          wait_d  = '0;
        end else if (wait_q == LAST_WAIT) begin
          state_d = MIX;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      MIX: begin
        state_we = 1'b1;
        key_we   = 1'b1;
        busy     = 1'b1;
        wait_d   = '0;
        if (load_s) begin
          state_d = IDLE;
          round_d = '0;
        end else if (round_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          state_d = SUB;
          round_d = round_q + 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (load_s) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        wait_d  = '0;
      end
    endcase
  end

  // Round-dependent outputs only matter while a round is in flight.
  logic in_round;
  assign in_round   = (state_q == SUB) || (state_q == MIX);
  assign last_round = in_round && (round_q == LAST_ROUND);
  assign rcon       = in_round ? aes_rcon(4'(round_q)) : 8'h00;
  assign round      = 4'(round_q);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: two instances (SBOX_LAT 1 and 2) share
// the load/reset stimulus and are checked every cycle against a timeline model.
module tb_aes_round_ctrl;

  localparam int NR   = 10;
  localparam int SYNC = 2;

  typedef struct packed {
    logic       init_we;
    logic       sbox_en;
    logic       state_we;
    logic       key_we;
    logic       last_round;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct packed {
    outs_t a;
    outs_t b;
  } pair_t;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic load  = 1'b0;

  always #5 clk = ~clk;

  logic       init_we_a, sbox_en_a, state_we_a, key_we_a, last_round_a, busy_a, done_a;
  logic [3:0] round_a;
  logic [7:0] rcon_a;
  logic       init_we_b, sbox_en_b, state_we_b, key_we_b, last_round_b, busy_b, done_b;
  logic [3:0] round_b;
  logic [7:0] rcon_b;

  aes_round_ctrl #(.NR(NR), .SBOX_LAT(1), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .reset(reset), .load(load),
    .init_we(init_we_a), .sbox_en(sbox_en_a), .state_we(state_we_a), .key_we(key_we_a),
    .last_round(last_round_a), .round(round_a), .rcon(rcon_a), .busy(busy_a), .done(done_a)
  );

  aes_round_ctrl #(.NR(NR), .SBOX_LAT(2), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .reset(reset), .load(load),
    .init_we(init_we_b), .sbox_en(sbox_en_b), .state_we(state_we_b), .key_we(key_we_b),
    .last_round(last_round_b), .round(round_b), .rcon(rcon_b), .busy(busy_b), .done(done_b)
  );

  outs_t act_a, act_b;
  assign act_a = {init_we_a, sbox_en_a, state_we_a, key_we_a, last_round_a, round_a, rcon_a, busy_a, done_a};
  assign act_b = {init_we_b, sbox_en_b, state_we_b, key_we_b, last_round_b, round_b, rcon_b, busy_b, done_b};

  // Reference model: load history plus, per instance, a mode and the number
  // of cycles since INIT; outputs follow arithmetically from that count.
  logic [7:0] rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic  smp  [0:SYNC] = '{default: 1'b0};
  mode_t mode [2]      = '{M_IDLE, M_IDLE};
  int    t    [2]      = '{0, 0};
  int    lat  [2]      = '{1, 2};

  pair_t sb_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    cyc        = 0;

  function automatic outs_t model_outs(mode_t m, int tt, int l);
    outs_t o;
    int    r, ph;
    o = '0;
    case (m)
      M_RUN: begin
        o.busy = 1'b1;
        if (tt == 0) begin
          o.init_we = 1'b1;
        end else begin
          r            = (tt - 1) / (l + 1) + 1;
          ph           = (tt - 1) % (l + 1);
          o.round      = 4'(r);
          o.rcon       = rcon_tab[r];
          o.last_round = (r == NR);
          o.sbox_en    = (ph < l);
          o.state_we   = (ph == l);
          o.key_we     = (ph == l);
        end
      end
      M_DONE: begin
        o.done  = 1'b1;
        o.round = 4'(NR);
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic model_edge();
    logic ls_prev, start_prev;
    ls_prev    = smp[SYNC-1];
    start_prev = smp[SYNC] & ~smp[SYNC-1];
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mode[k] = M_IDLE;
      end else begin
        case (mode[k])
          M_IDLE: if (start_prev) begin
            mode[k] = M_RUN;
            t[k]    = 0;
          end
          M_RUN: begin
            if (ls_prev) begin
              mode[k] = M_IDLE;
            end else begin
              t[k]++;
              if (t[k] > NR * (lat[k] + 1)) mode[k] = M_DONE;
            end
          end
          M_DONE: if (ls_prev) mode[k] = M_IDLE;
          default: mode[k] = M_IDLE;
        endcase
      end
    end
    if (reset) begin
      for (int i = 0; i <= SYNC; i++) smp[i] = 1'b0;
    end else begin
      for (int i = SYNC; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = load;
    end
  endtask

  // Drive one cycle of stimulus and queue what both instances must show after
  // the coming rising edge.
  task automatic step(input logic ld, input logic rst);
    pair_t e;
    @(negedge clk);
    load  = ld;
    reset = rst;
    model_edge();
    e.a = model_outs(mode[0], t[0], lat[0]);
    e.b = model_outs(mode[1], t[1], lat[1]);
    sb_q.push_back(e);
  endtask

  task automatic hold(input logic ld, input int n);
    repeat (n) step(ld, 1'b0);
  endtask

  task automatic check(input string name, input outs_t got, input outs_t exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got{iwe,sbx,swe,kwe,last,rnd,rcon,busy,done}=%b,%b,%b,%b,%b,%0d,%h,%b,%b exp=%b,%b,%b,%b,%b,%0d,%h,%b,%b",
               name, cyc,
               got.init_we, got.sbox_en, got.state_we, got.key_we, got.last_round,
               got.round, got.rcon, got.busy, got.done,
               exp.init_we, exp.sbox_en, exp.state_we, exp.key_we, exp.last_round,
               exp.round, exp.rcon, exp.busy, exp.done);
    end
  endtask

  // Monitor: one expected record per rising edge, compared just after it.
  initial begin
    forever begin
      pair_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("dut_a", act_a, e.a);
        check("dut_b", act_b, e.b);
      end
    end
  end

  initial begin
    // Reset with load toggling underneath it.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Full run, done held, then a restart and a second identical run.
    hold(1'b1, 256);
    hold(1'b0, 140);
    hold(1'b1, 10);
    hold(1'b0, 140);

    // Abort in round 5 SUB of the SBOX_LAT=1 instance, then a clean run.
    hold(1'b1, 8);
    hold(1'b0, 10);
    hold(1'b1, 20);
    hold(1'b0, 140);

    // Reset in round 3 MIX; load stays low afterwards and must not start.
    hold(1'b1, 8);
    hold(1'b0, 9);
    step(1'b0, 1'b1);
    hold(1'b0, 30);

    // Random load pulse trains with occasional reset pulses.
    repeat (40) begin
      if ($urandom_range(0, 9) == 0) step(1'($urandom_range(0, 1)), 1'b1);
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 40));
    end
    hold(1'b1, 3);

    repeat (2) @(posedge clk);
    #2;
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d required=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
